keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 19 +
 rtl/keypad_scanner_onehot_encode.sv | 30 +++
 rtl/keypad_scanner.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared FSM state, debounce counter width and key-code helper for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_HELD      = 2'd2,
        ST_DEB_REL   = 2'd3
    } kp_state_e;

    localparam int unsigned DEB_CNT_W = 4;

    function automatic int unsigned calc_key_code(input int unsigned col_idx,
                                                  input int unsigned row_idx,
                                                  input int unsigned rows);
        return col_idx * rows + row_idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_onehot_encode.sv
// rtl/keypad_scanner_onehot_encode.sv - one-hot to binary index, valid only when exactly one bit is set
module onehot_encode
    import keypad_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     onehot_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic seen;
    logic multi;

    always_comb begin
        idx_o = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | IDX_W'(i);
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
        valid_o = seen & ~multi;
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - debounced keypad scanner with valid/ready event output
// Release events are emitted only when KEYPAD_SCANNER_RELEASE_EVT_EN is defined.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int COLS     = 4,
    parameter int ROWS     = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [COLS-1:0]               col_drv,
    input  logic [ROWS-1:0]               row_in,
    output logic [$clog2(COLS*ROWS)-1:0]  key_code,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic                          key_rel,
    output logic                          onehot_err,
    output logic                          overflow
);

    localparam int CI_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RI_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KC_W = $clog2(COLS * ROWS);
    localparam logic [DEB_CNT_W-1:0] DEB_LIM = DEB_CNT_W'(DEBOUNCE);
`ifdef KEYPAD_SCANNER_RELEASE_EVT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic [COLS-1:0]      col_q;
    logic [ROWS-1:0]      row_q;
    logic                 smp_vld_q;
    kp_state_e            state_q, state_d;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CI_W-1:0]      cand_col_q, cand_col_d, col_idx;
    logic [RI_W-1:0]      cand_row_q, cand_row_d, row_idx;
    logic                 col_ok, row_one, sample_ok, on_cand, cand_row_set, only_cand;
    logic                 emit, emit_rel, rel_done;
    logic [KC_W-1:0]      key_code_q, key_code_d;
    logic                 key_valid_q, key_rel_q, onehot_err_q, overflow_q;

    // smp_vld_q keeps the cleared input registers from looking like a bad strobe
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_q     <= '0;
            row_q     <= '0;
            smp_vld_q <= 1'b0;
        end else begin
            col_q     <= col_drv;
            row_q     <= row_in;
            smp_vld_q <= 1'b1;
        end
    end

    onehot_encode #(.N(COLS), .IDX_W(CI_W)) u_col_enc (
        .onehot_i (col_q),
        .idx_o    (col_idx),
        .valid_o  (col_ok)
    );

    onehot_encode #(.N(ROWS), .IDX_W(RI_W)) u_row_enc (
        .onehot_i (row_q),
        .idx_o    (row_idx),
        .valid_o  (row_one)
    );

    assign sample_ok    = smp_vld_q & col_ok;
    assign on_cand      = sample_ok && (col_idx == cand_col_q);
    assign cand_row_set = row_q[cand_row_q];
    assign only_cand    = (row_q == (ROWS'(1) << cand_row_q));
    assign cnt_inc      = cnt_q + DEB_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cand_col_q <= '0;
            cand_row_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_col_q <= cand_col_d;
            cand_row_q <= cand_row_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_col_d = cand_col_q;
        cand_row_d = cand_row_q;
        emit       = 1'b0;
        emit_rel   = 1'b0;
        rel_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample_ok && row_one) begin
                    cand_col_d = col_idx;
                    cand_row_d = row_idx;
                    cnt_d      = DEB_CNT_W'(1);
                    if (DEB_LIM == DEB_CNT_W'(1)) begin
                        emit    = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        state_d = ST_DEB_PRESS;
                    end
                end
            end
            ST_DEB_PRESS: begin
                if (on_cand) begin
                    if (only_cand) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LIM) begin
                            emit    = 1'b1;
                            state_d = ST_HELD;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HELD: begin
                if (on_cand && !cand_row_set) begin
                    cnt_d = DEB_CNT_W'(1);
                    if (DEB_LIM == DEB_CNT_W'(1)) begin
                        rel_done = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_DEB_REL;
                    end
                end
            end
            default: begin
                if (on_cand) begin
                    if (cand_row_set) begin
                        state_d = ST_HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LIM) begin
                            rel_done = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                end
            end
        endcase
        if (rel_done && REL_EN) begin
            emit     = 1'b1;
            emit_rel = 1'b1;
        end
    end

    // _d candidate covers DEBOUNCE=1, where the key is captured and emitted together
    assign key_code_d = KC_W'(calc_key_code(32'(cand_col_d), 32'(cand_row_d), ROWS));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            key_code_q   <= '0;
            key_valid_q  <= 1'b0;
            key_rel_q    <= 1'b0;
            onehot_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (emit) begin
                if (!key_valid_q || key_ready) begin
                    key_code_q  <= key_code_d;
                    key_rel_q   <= emit_rel;
                    key_valid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (key_valid_q && key_ready) begin
                key_valid_q <= 1'b0;
            end
            if (smp_vld_q && !col_ok) begin
                onehot_err_q <= 1'b1;
            end
        end
    end

    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;
    assign key_rel    = key_rel_q & REL_EN;
    assign onehot_err = onehot_err_q;
    assign overflow   = overflow_q;

endmodule
